// File: rtl/counter_pkg.sv
// counter_pkg: shared types and helpers for mod_updown_counter.
//   state_e    - FSM encoding (IDLE/RUN/DONE)
//   DIR_UP/DN  - values of the `up` direction input
//   next_count - next count value and terminal flag for one counting step
package counter_pkg;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef struct packed {
        logic             term;
        logic [CNT_W-1:0] val;
    } step_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // cur is always in 0..modulus-1, so neither branch ever forms a value
    // above modulus-1 (cur+1 is only taken when cur < modulus-1).
    function automatic step_t next_count(input logic [CNT_W-1:0] cur,
                                         input logic             up,
                                         input logic [CNT_W-1:0] modulus,
                                         input logic             sat);
        step_t r;
        r.term = 1'b0;
        r.val  = cur;
        if (up == DIR_UP) begin
            if (cur == modulus - ONE) begin
                r.term = 1'b1;
                r.val  = sat ? cur : '0;
            end else begin
                r.val = cur + ONE;
            end
        end else begin
            if (cur == '0) begin
                r.term = 1'b1;
                r.val  = sat ? '0 : modulus - ONE;
            end else begin
                r.val = cur - ONE;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/udcnt_fsm.sv
// udcnt_fsm: IDLE/RUN/DONE control for mod_updown_counter.
//   clk_i, rst_ni        - clock, async active-low reset
//   start_i, stop_i      - run requests (stop wins)
//   load_i               - parallel load strobe (leaves DONE for IDLE)
//   en_i                 - raw count enable
//   oneshot_i, term_i    - one-shot mode, terminal event this cycle
//   cnt_en_o             - count qualifier (RUN and en)
//   busy_o, done_o       - state flags, decoded from the state register
module udcnt_fsm
    import counter_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic stop_i,
    input  logic load_i,
    input  logic en_i,
    input  logic oneshot_i,
    input  logic term_i,
    output logic cnt_en_o,
    output logic busy_o,
    output logic done_o
);

    state_e state_q, state_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_en_o = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                busy_o   = 1'b1;
                cnt_en_o = en_i;
                if (stop_i)                      state_d = ST_IDLE;
                else if (term_i && oneshot_i)    state_d = ST_DONE;
            end
            ST_DONE: begin
                done_o = 1'b1;
                if (stop_i || load_i) state_d = ST_IDLE;
                else if (start_i)     state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-MODULUS up/down counter with load, run/stop
// and one-shot control. All outputs are registered.
//   clk, reset (async, active low)
//   en, up, load, load_val, start, stop, oneshot - controls
//   q    - count, wrap - one-cycle terminal-event pulse
//   busy - RUN state, done - DONE state
// Build option: UDCNT_SATURATE_EN makes the count hold at the end of range
// instead of wrapping; the overrun attempt is still a terminal event.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             busy,
    output logic             done
);

    if (WIDTH < 1 || WIDTH > 31 || MODULUS < 2 ||
        64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_param
        $error("mod_updown_counter: illegal WIDTH/MODULUS combination");
    end

`ifdef UDCNT_SATURATE_EN
    localparam logic SATURATE = 1'b1;
`else
    localparam logic SATURATE = 1'b0;
`endif

    localparam int unsigned      W1     = WIDTH + 1;
    localparam logic [W1-1:0]    MOD_W1 = W1'(MODULUS);
    localparam logic [WIDTH-1:0] Q_MAX  = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             cnt_en, term;
    logic [WIDTH-1:0] load_clamped;
    step_t            step;

    udcnt_fsm u_fsm (
        .clk_i     (clk),
        .rst_ni    (reset),
        .start_i   (start),
        .stop_i    (stop),
        .load_i    (load),
        .en_i      (en),
        .oneshot_i (oneshot),
        .term_i    (term),
        .cnt_en_o  (cnt_en),
        .busy_o    (busy),
        .done_o    (done)
    );

    always_comb begin
        step         = next_count(CNT_W'(q_q), up, CNT_W'(MODULUS), SATURATE);
        load_clamped = ({1'b0, load_val} >= MOD_W1) ? Q_MAX : load_val;
        // A load suppresses the terminal event, so it cannot pulse wrap
        // nor push a one-shot run into DONE.
        term   = cnt_en & ~load & step.term;
        q_d    = q_q;
        wrap_d = term;
        if (load) begin
            q_d = load_clamped;
        end else if (cnt_en) begin
            q_d = WIDTH'(step.val);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0, up = 1'b1, load = 1'b0;
    logic       start = 1'b0, stop = 1'b0, oneshot = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] q10, q16;
    logic [0:0] q2;
    logic       wrap10, busy10, done10;
    logic       wrap16, busy16, done16;
    logic       wrap2, busy2, done2;

    int errors = 0;
    int checks = 0;

`ifdef UDCNT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    always #5 clk = ~clk;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .start(start), .stop(stop), .oneshot(oneshot),
        .q(q10), .wrap(wrap10), .busy(busy10), .done(done10));

    mod_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val), .start(start), .stop(stop), .oneshot(oneshot),
        .q(q16), .wrap(wrap16), .busy(busy16), .done(done16));

    mod_updown_counter #(.WIDTH(1), .MODULUS(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load),
        .load_val(load_val[0:0]), .start(start), .stop(stop), .oneshot(oneshot),
        .q(q2), .wrap(wrap2), .busy(busy2), .done(done2));

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: state 0=idle 1=run 2=done, count as plain integers.
    int mods[3] = '{10, 16, 2};
    int mq[3]   = '{0, 0, 0};
    int mst[3]  = '{0, 0, 0};
    bit mw[3]   = '{0, 0, 0};

    always @(posedge clk or negedge reset) begin
        for (int k = 0; k < 3; k++) begin
            int m, lv, nq;
            bit term;
            if (!reset) begin
                mq[k] = 0; mst[k] = 0; mw[k] = 0;
            end else begin
                m    = mods[k];
                lv   = (k == 2) ? int'(load_val[0]) : int'(load_val);
                term = 1'b0;
                nq   = mq[k];
                if (load) begin
                    nq = (lv >= m) ? m - 1 : lv;
                end else if (mst[k] == 1 && en) begin
                    if (up) begin
                        term = (mq[k] == m - 1);
                        nq   = (term && SAT) ? mq[k] : (mq[k] + 1) % m;
                    end else begin
                        term = (mq[k] == 0);
                        nq   = (term && SAT) ? 0 : (mq[k] + m - 1) % m;
                    end
                end
                case (mst[k])
                    0: if (start && !stop) mst[k] = 1;
                    1: if (stop) mst[k] = 0; else if (term && oneshot) mst[k] = 2;
                    default: if (stop || load) mst[k] = 0; else if (start) mst[k] = 1;
                endcase
                mq[k] = nq;
                mw[k] = term;
            end
        end
    end

    task automatic cmp(input int k, input int gq, input logic gw, input logic gb, input logic gd);
        chk($sformatf("model m%0d q", mods[k]), gq, mq[k]);
        chk($sformatf("model m%0d wrap", mods[k]), int'(gw), int'(mw[k]));
        chk($sformatf("model m%0d busy", mods[k]), int'(gb), int'(mst[k] == 1));
        chk($sformatf("model m%0d done", mods[k]), int'(gd), int'(mst[k] == 2));
    endtask

    always @(negedge clk) begin
        cmp(0, int'(q10), wrap10, busy10, done10);
        cmp(1, int'(q16), wrap16, busy16, done16);
        cmp(2, int'(q2),  wrap2,  busy2,  done2);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

`ifdef UDCNT_SATURATE_EN
    int up_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
`else
    int up_seq[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
`endif

    initial begin
        tick(); tick();
        reset = 1'b1;
        chk("rst q", int'(q10), 0);
        chk("rst busy", int'(busy10), 0);
        chk("rst done", int'(done10), 0);
        chk("rst wrap", int'(wrap10), 0);

        start = 1'b1; en = 1'b1; up = 1'b1;
        tick();
        chk("start busy", int'(busy10), 1);
        chk("start q", int'(q10), 0);
        start = 1'b0;

        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("up q[%0d]", i), int'(q10), up_seq[i]);
`ifndef UDCNT_SATURATE_EN
            chk($sformatf("up wrap[%0d]", i), int'(wrap10), (i == 9) ? 1 : 0);
`endif
        end
        chk("up busy", int'(busy10), 1);
        chk("m16 q12", int'(q16), 12);
        chk("m2 wrap", int'(wrap2), 1);

        load = 1'b1; load_val = 4'd0;
        tick();
        chk("load0 q", int'(q10), 0);
        load = 1'b0;

        up = 1'b0;
        tick();
`ifndef UDCNT_SATURATE_EN
        chk("down wrap q", int'(q10), 9);
        chk("down wrap m16", int'(q16), 15);
`endif
        chk("down wrap", int'(wrap10), 1);
        tick();
`ifndef UDCNT_SATURATE_EN
        chk("down 8", int'(q10), 8);
        tick();
        chk("down 7", int'(q10), 7);
        chk("down 7 wrap", int'(wrap10), 0);
        up = 1'b1;
        tick();
        chk("flip up 8", int'(q10), 8);
        oneshot = 1'b1;
        tick();
        chk("os 9", int'(q10), 9);
        tick();
        chk("os q0", int'(q10), 0);
        chk("os wrap", int'(wrap10), 1);
        chk("os done", int'(done10), 1);
        chk("os busy", int'(busy10), 0);
        chk("os m16 done", int'(done16), 1);
        tick();
        chk("done hold q", int'(q10), 0);
        chk("done hold wrap", int'(wrap10), 0);
        oneshot = 1'b0; start = 1'b1;
        tick();
        chk("restart busy", int'(busy10), 1);
        chk("restart done", int'(done10), 0);
        start = 1'b0;
        tick();
        chk("restart q1", int'(q10), 1);
`else
        tick();
        up = 1'b1;
        tick();
        oneshot = 1'b1;
        tick(); tick(); tick();
        oneshot = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
`endif
        en = 1'b0;
        tick();
        chk("en low wrap", int'(wrap10), 0);
        en = 1'b1;

        load = 1'b1; load_val = 4'd4;
        tick();
        chk("load4", int'(q10), 4);
        load_val = 4'd13;
        tick();
        chk("clamp q", int'(q10), 9);
        chk("clamp wrap", int'(wrap10), 0);
        chk("clamp m16", int'(q16), 13);
        load_val = 4'd5;
        tick();
        chk("load over term q", int'(q10), 5);
        chk("load over term wrap", int'(wrap10), 0);
        load = 1'b0;

        stop = 1'b1;
        tick();
        chk("stop busy", int'(busy10), 0);
        chk("stop last count", int'(q10), 6);
        start = 1'b1;
        tick();
        chk("start+stop busy", int'(busy10), 0);
        chk("start+stop q", int'(q10), 6);
        stop = 1'b0;
        tick();
        chk("run again", int'(busy10), 1);
        start = 1'b0;
        tick();
        chk("pre-reset q", int'(q10), 7);

        #1 reset = 1'b0;
        #1;
        chk("async rst q", int'(q10), 0);
        chk("async rst busy", int'(busy10), 0);
        chk("async rst m16 q", int'(q16), 0);
        @(negedge clk);
        reset = 1'b1;

        load = 1'b1; load_val = 4'd15;
        tick();
        chk("m16 load15", int'(q16), 15);
        chk("m10 clamp15", int'(q10), 9);
        load = 1'b0; start = 1'b1; up = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("m16 overrun wrap", int'(wrap16), 1);
        chk("m16 overrun q", int'(q16), SAT ? 15 : 0);
        tick();
        chk("m16 next q", int'(q16), SAT ? 15 : 1);
        chk("m16 next wrap", int'(wrap16), SAT ? 1 : 0);

        load = 1'b1; load_val = 4'd0;
        tick();
        load = 1'b0; up = 1'b0;
        tick();
        chk("m16 under q", int'(q16), SAT ? 0 : 15);
        chk("m16 under wrap", int'(wrap16), 1);

        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
